// File: rtl/mpt_check_stage.sv
// mpt_check_stage
//   Permission-check stage behind the memory-protection-table walker. Each
//   walked transaction carries its access type, a walk-fault flag, the leaf
//   MPTE and the physical address. The stage selects the permission nibble
//   for the address, resolves a grant/deny cause, writes the grant bit and
//   forwards the transaction through a single output register (1-cycle
//   latency, full throughput). Denied transactions raise a one-cycle fault
//   pulse, bump a saturating fault counter and may be captured as the first
//   fault.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   stage_slave_valid_i/ready_o  upstream handshake
//   stage_slave_data_i           walked transaction
//   stage_master_valid_o/ready_i downstream handshake
//   stage_master_data_o          checked transaction (bit[3] = grant)
//   fault_valid_o, fault_cause_o pulse + cause for each denied transaction
//   fault_count_o                saturating count of denied transactions
//   first_fault_valid_o/addr_o/cause_o  sticky first-fault capture
//   clear_i                      clears the counter and first-fault capture
//
// Data layout: [1:0] access type (00 R, 01 W, 10 X, 11 reserved),
//   [2] walk fault, [3] grant, [67:4] leaf MPTE, [68 +: PA_WIDTH] PA.
// Cause: 00 grant, 01 walk fault, 10 invalid nibble, 11 permission denied.
module mpt_check_stage #(
  parameter int PIPELINE_DATA_WIDTH = 124,
  parameter int PA_WIDTH            = 56,
  parameter int FAULT_COUNT_WIDTH   = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           stage_slave_valid_i,
  output logic                           stage_slave_ready_o,
  input  logic [PIPELINE_DATA_WIDTH-1:0] stage_slave_data_i,
  output logic                           stage_master_valid_o,
  input  logic                           stage_master_ready_i,
  output logic [PIPELINE_DATA_WIDTH-1:0] stage_master_data_o,
  output logic                           fault_valid_o,
  output logic [1:0]                     fault_cause_o,
  output logic [FAULT_COUNT_WIDTH-1:0]   fault_count_o,
  output logic                           first_fault_valid_o,
  output logic [PA_WIDTH-1:0]            first_fault_addr_o,
  output logic [1:0]                     first_fault_cause_o,
  input  logic                           clear_i
);

  localparam int PA_LSB = 68;

  // The nibble select uses PA[15:12], so the address must be at least 16 bits.
  if ((PIPELINE_DATA_WIDTH < PA_LSB + PA_WIDTH) || (PA_WIDTH < 16)) begin : g_bad_params
    $error("mpt_check_stage: PIPELINE_DATA_WIDTH must be >= 68 + PA_WIDTH and PA_WIDTH >= 16");
  end

  // Field decode
  logic [1:0]          acc_type;
  logic                walk_fault;
  logic [63:0]         leaf;
  logic [PA_WIDTH-1:0] pa;
  logic [3:0]          perm;
  logic                perm_ok;
  logic [1:0]          cause;

  assign acc_type   = stage_slave_data_i[1:0];
  assign walk_fault = stage_slave_data_i[2];
  assign leaf       = stage_slave_data_i[67:4];
  assign pa         = stage_slave_data_i[PA_LSB +: PA_WIDTH];
  // Nibble index PA[15:12] scaled by 4 to get the bit offset in the leaf.
  assign perm       = leaf[{pa[15:12], 2'b00} +: 4];

  always_comb begin
    perm_ok = 1'b0;
    case (acc_type)
      2'b00:   perm_ok = perm[0];
      2'b01:   perm_ok = perm[1];
      2'b10:   perm_ok = perm[2];
      default: perm_ok = 1'b0; // reserved access type never grants
    endcase
  end

  always_comb begin
    if (walk_fault)     cause = 2'b01;
    else if (!perm[3])  cause = 2'b10;
    else if (!perm_ok)  cause = 2'b11;
    else                cause = 2'b00;
  end

  // Handshake
  logic master_valid_q, master_valid_d;
  logic [PIPELINE_DATA_WIDTH-1:0] master_data_q, master_data_d;
  logic slave_fire, master_fire, denied_fire;

  assign stage_slave_ready_o = !rst_i && (!master_valid_q || stage_master_ready_i);
  assign slave_fire          = stage_slave_valid_i && stage_slave_ready_o;
  assign master_fire         = master_valid_q && stage_master_ready_i;
  assign denied_fire         = slave_fire && (cause != 2'b00);

  // Fault reporting state
  logic                         fault_valid_q, fault_valid_d;
  logic [1:0]                   fault_cause_q, fault_cause_d;
  logic [FAULT_COUNT_WIDTH-1:0] fault_count_q, fault_count_d, count_base;
  logic                         ff_valid_q, ff_valid_d, ff_valid_base;
  logic [PA_WIDTH-1:0]          ff_addr_q, ff_addr_d;
  logic [1:0]                   ff_cause_q, ff_cause_d;

  always_comb begin
    master_valid_d = master_valid_q;
    master_data_d  = master_data_q;
    if (slave_fire) begin
      master_valid_d   = 1'b1;
      master_data_d    = stage_slave_data_i;
      master_data_d[3] = (cause == 2'b00);
    end else if (master_fire) begin
      master_valid_d = 1'b0;
    end

    // The pulse lines up with the first cycle the denied transaction is
    // presented, because both are loaded on the same slave fire.
    fault_valid_d = denied_fire;
    fault_cause_d = denied_fire ? cause : 2'b00;

    // Clear takes effect before a coincident denial is counted/captured.
    count_base    = clear_i ? '0 : fault_count_q;
    fault_count_d = count_base;
    if (denied_fire && (count_base != '1))
      fault_count_d = count_base + {{(FAULT_COUNT_WIDTH-1){1'b0}}, 1'b1};

    ff_valid_base = clear_i ? 1'b0 : ff_valid_q;
    ff_valid_d    = ff_valid_base;
    ff_addr_d     = ff_addr_q;
    ff_cause_d    = ff_cause_q;
    if (denied_fire && !ff_valid_base) begin
      ff_valid_d = 1'b1;
      ff_addr_d  = pa;
      ff_cause_d = cause;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      master_valid_q <= 1'b0;
      master_data_q  <= '0;
      fault_valid_q  <= 1'b0;
      fault_cause_q  <= 2'b00;
      fault_count_q  <= '0;
      ff_valid_q     <= 1'b0;
      ff_addr_q      <= '0;
      ff_cause_q     <= 2'b00;
    end else begin
      master_valid_q <= master_valid_d;
      master_data_q  <= master_data_d;
      fault_valid_q  <= fault_valid_d;
      fault_cause_q  <= fault_cause_d;
      fault_count_q  <= fault_count_d;
      ff_valid_q     <= ff_valid_d;
      ff_addr_q      <= ff_addr_d;
      ff_cause_q     <= ff_cause_d;
    end
  end

  assign stage_master_valid_o = master_valid_q;
  assign stage_master_data_o  = master_data_q;
  assign fault_valid_o        = fault_valid_q;
  assign fault_cause_o        = fault_cause_q;
  assign fault_count_o        = fault_count_q;
  assign first_fault_valid_o  = ff_valid_q;
  assign first_fault_addr_o   = ff_addr_q;
  assign first_fault_cause_o  = ff_cause_q;

endmodule

// File: tb/tb_mpt_check_stage.sv
// Bench for mpt_check_stage: directed scenarios plus randomized traffic.
// Driver pushes expected outputs into queues at each accepted transaction;
// a negedge monitor pops and compares whenever the DUT presents output.
module tb_mpt_check_stage;
  localparam int W  = 124;
  localparam int PA = 56;
  localparam int FC = 4;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          svalid = 1'b0;
  logic          sready;
  logic [W-1:0]  sdata = '0;
  logic          mvalid;
  logic          mready = 1'b1;
  logic [W-1:0]  mdata;
  logic          fvalid;
  logic [1:0]    fcause;
  logic [FC-1:0] fcount;
  logic          ffvalid;
  logic [PA-1:0] ffaddr;
  logic [1:0]    ffcause;
  logic          clear_i = 1'b0;

  mpt_check_stage #(
    .PIPELINE_DATA_WIDTH(W),
    .PA_WIDTH(PA),
    .FAULT_COUNT_WIDTH(FC)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .stage_slave_valid_i(svalid),
    .stage_slave_ready_o(sready),
    .stage_slave_data_i(sdata),
    .stage_master_valid_o(mvalid),
    .stage_master_ready_i(mready),
    .stage_master_data_o(mdata),
    .fault_valid_o(fvalid),
    .fault_cause_o(fcause),
    .fault_count_o(fcount),
    .first_fault_valid_o(ffvalid),
    .first_fault_addr_o(ffaddr),
    .first_fault_cause_o(ffcause),
    .clear_i(clear_i)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state
  logic [W-1:0]  out_q[$];
  logic [1:0]    fault_q[$];
  int            exp_count = 0;
  bit            exp_ffv = 0;
  logic [PA-1:0] exp_ffaddr = '0;
  logic [1:0]    exp_ffcause = 2'b00;
  int            rdy_mode = 0; // 0: ready high, 1: random, 2: ready low
  int            cyc = 0;
  int            pulses = 0;
  int            fire_cyc[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cause from the rules: walk fault, then valid bit, then access permission.
  function automatic logic [1:0] ref_cause(input logic [W-1:0] d);
    int          idx;
    logic [63:0] lf;
    logic [3:0]  nib;
    idx = int'(d[80 +: 4]);
    lf  = d[67:4];
    nib = 4'((lf >> (idx * 4)) & 64'hF);
    if (d[2]) return 2'b01;
    if (!nib[3]) return 2'b10;
    case (d[1:0])
      2'b00:   return nib[0] ? 2'b00 : 2'b11;
      2'b01:   return nib[1] ? 2'b00 : 2'b11;
      2'b10:   return nib[2] ? 2'b00 : 2'b11;
      default: return 2'b11;
    endcase
  endfunction

  function automatic logic [W-1:0] mk(input logic [1:0] typ, input bit walk,
                                      input logic [PA-1:0] pa, input logic [63:0] leaf,
                                      input bit gin);
    logic [W-1:0] d;
    d = '0;
    d[1:0] = typ;
    d[2] = walk;
    d[3] = gin;
    d[67:4] = leaf;
    d[68 +: PA] = pa;
    return d;
  endfunction

  function automatic logic [63:0] set_nib(input logic [63:0] leaf, input int idx, input logic [3:0] v);
    logic [63:0] m;
    m = 64'hF << (idx * 4);
    return (leaf & ~m) | (64'(v) << (idx * 4));
  endfunction

  function automatic logic [PA-1:0] rand_pa();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[PA-1:0];
  endfunction

  task automatic model_accept(input logic [W-1:0] d);
    logic [1:0]   c;
    logic [W-1:0] e;
    c = ref_cause(d);
    e = d;
    e[3] = (c == 2'b00);
    out_q.push_back(e);
    if (c != 2'b00) begin
      fault_q.push_back(c);
      if (exp_count < (1 << FC) - 1) exp_count++;
      if (!exp_ffv) begin
        exp_ffv = 1;
        exp_ffaddr = d[68 +: PA];
        exp_ffcause = c;
      end
    end
  endtask

  task automatic model_clear();
    exp_count = 0;
    exp_ffv = 0;
  endtask

  task automatic model_reset();
    out_q.delete();
    fault_q.delete();
    exp_count = 0;
    exp_ffv = 0;
    exp_ffaddr = '0;
    exp_ffcause = 2'b00;
  endtask

  // All main-thread actions happen at posedge+1.
  task automatic send(input logic [W-1:0] d, input bit clr);
    bit fired;
    int n;
    svalid = 1'b1;
    sdata = d;
    clear_i = clr;
    fired = 0;
    n = 0;
    while (!fired && n < 100) begin
      @(negedge clk);
      fired = sready;
      n++;
      @(posedge clk);
      #1;
      if (clr) model_clear();
      if (fired) model_accept(d);
    end
    svalid = 1'b0;
    clear_i = 1'b0;
    if (!fired) chk("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_cycle();
    clear_i = 1'b1;
    @(posedge clk);
    #1;
    model_clear();
    clear_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    model_reset();
  endtask

  // Downstream ready driver
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       mready = 1'b1;
        1:       mready = ($urandom_range(0, 3) != 0);
        default: mready = 1'b0;
      endcase
    end
  end

  // Monitor / scoreboard
  initial begin
    bit pv, pr, post_rst, newp;
    logic [W-1:0] pd;
    pv = 0; pr = 0; post_rst = 0; pd = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_i) begin
        chk("ready_in_reset", sready, 0);
        pv = 0;
        post_rst = 1;
      end else begin
        if (post_rst) begin
          chk("rst_mvalid", mvalid, 0);
          chk("rst_mdata", mdata, 0);
          chk("rst_fvalid", fvalid, 0);
          chk("rst_fcause", fcause, 0);
          chk("rst_count", fcount, 0);
          chk("rst_ffvalid", ffvalid, 0);
          chk("rst_ffaddr", ffaddr, 0);
          chk("rst_ffcause", ffcause, 0);
          post_rst = 0;
        end
        chk("slave_ready", sready, (!mvalid || mready));
        if (pv && !pr) begin
          chk("stall_valid", mvalid, 1);
          chk("stall_data", mdata, pd);
        end
        newp = mvalid && !(pv && !pr);
        chk("fault_pulse", fvalid, newp && !mdata[3]);
        if (fvalid) begin
          pulses++;
          if (fault_q.size() == 0) chk("fault_unexpected", 1, 0);
          else chk("fault_cause", fcause, fault_q.pop_front());
        end
        chk("fault_count", fcount, exp_count);
        chk("ff_valid", ffvalid, exp_ffv);
        if (exp_ffv) begin
          chk("ff_addr", ffaddr, exp_ffaddr);
          chk("ff_cause", ffcause, exp_ffcause);
        end
        if (mvalid && mready) begin
          fire_cyc.push_back(cyc);
          if (out_q.size() == 0) chk("out_unexpected", 1, 0);
          else chk("out_data", mdata, out_q.pop_front());
        end
        pv = mvalid;
        pr = mready;
        pd = mdata;
      end
    end
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PA-1:0] pa;
    logic [63:0]   leaf;
    int            p0;
    int            c0;

    rst_i = 1'b1;
    idle(3);
    rst_i = 1'b0;
    model_reset();
    idle(2);

    // Grant: W access, nibble 3 = 0xB
    pa = 56'h12_3456_789A_3000;
    leaf = set_nib(64'h0, 3, 4'hB);
    send(mk(2'b01, 0, pa, leaf, 0), 0);
    @(negedge clk);
    chk("grant_valid", mvalid, 1);
    chk("grant_bit", mdata[3], 1);
    chk("grant_nopulse", fvalid, 0);
    chk("grant_count", fcount, 0);
    idle(2);

    // Priority: walk fault beats V=0
    pa = 56'h00_0000_0ABC_5000;
    send(mk(2'b00, 1, pa, set_nib(64'hFFFF_FFFF_FFFF_FFFF, 5, 4'h0), 1), 0);
    @(negedge clk);
    chk("walk_pulse", fvalid, 1);
    chk("walk_cause", fcause, 2'b01);
    chk("walk_count", fcount, 1);
    chk("walk_ff_addr", ffaddr, 56'h00_0000_0ABC_5000);
    chk("walk_ff_cause", ffcause, 2'b01);
    idle(1);
    send(mk(2'b00, 0, 56'h7_7000, set_nib(64'hFFFF_FFFF_FFFF_FFFF, 7, 4'h7), 0), 0);
    @(negedge clk);
    chk("inv_cause", fcause, 2'b10);
    chk("inv_count", fcount, 2);
    chk("inv_ff_addr", ffaddr, 56'h00_0000_0ABC_5000);
    chk("inv_ff_cause", ffcause, 2'b01);
    idle(2);

    // Backpressure with a denied transaction held for 5 cycles
    rdy_mode = 2;
    p0 = pulses;
    send(mk(2'b10, 0, 56'h2000, set_nib(64'h0, 2, 4'hB), 0), 0);
    repeat (5) begin
      @(negedge clk);
      chk("bp_slave_ready", sready, 0);
      @(posedge clk);
      #1;
    end
    chk("bp_one_pulse", pulses - p0, 1);
    chk("bp_count", fcount, 3);
    rdy_mode = 0;
    idle(3);

    // Streaming: 8 back-to-back grants
    fire_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      pa = rand_pa();
      leaf = set_nib({$urandom(), $urandom()}, int'(pa[15:12]), 4'hF);
      send(mk(2'($urandom_range(0, 2)), 0, pa, leaf, 0), 0);
    end
    idle(3);
    chk("stream_outputs", fire_cyc.size(), 8);
    if (fire_cyc.size() == 8) chk("stream_consecutive", fire_cyc[7] - fire_cyc[0], 7);

    // Reserved access type with nibble 0xF
    send(mk(2'b11, 0, 56'h9000, set_nib(64'h0, 9, 4'hF), 1), 0);
    @(negedge clk);
    chk("rsv_cause", fcause, 2'b11);
    chk("rsv_grant", mdata[3], 0);
    idle(2);

    // Randomized traffic with random backpressure and occasional clear
    rdy_mode = 1;
    for (int i = 0; i < 200; i++) begin
      pa = rand_pa();
      leaf = {$urandom(), $urandom()};
      if ($urandom_range(0, 1) == 1)
        leaf = set_nib(leaf, int'(pa[15:12]), ($urandom_range(0, 1) == 1) ? 4'hF : {1'b1, 3'($urandom_range(0, 7))});
      send(mk(2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0), pa, leaf, 1'($urandom_range(0, 1))),
           ($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    rdy_mode = 0;
    idle(4);

    // Saturation and clear-with-denial
    clear_cycle();
    for (int i = 0; i < 17; i++)
      send(mk(2'b00, 1, rand_pa(), 64'h0, 0), 0);
    idle(2);
    chk("sat_count", fcount, 4'hF);
    pa = 56'h55_AAAA_1234_E000;
    send(mk(2'b01, 0, pa, 64'h0, 0), 1);
    @(negedge clk);
    chk("clr_count", fcount, 1);
    chk("clr_ff_valid", ffvalid, 1);
    chk("clr_ff_addr", ffaddr, 56'h55_AAAA_1234_E000);
    chk("clr_ff_cause", ffcause, 2'b10);
    idle(2);

    // Reset while output stalled
    rdy_mode = 2;
    send(mk(2'b00, 1, 56'h4000, 64'h0, 0), 0);
    idle(2);
    c0 = pulses;
    do_reset();
    rdy_mode = 0;
    @(negedge clk);
    chk("rst_stall_valid", mvalid, 0);
    chk("rst_stall_count", fcount, 0);
    chk("rst_stall_ffvalid", ffvalid, 0);
    chk("rst_stall_nopulse", pulses - c0, 0);
    idle(3);

    chk("out_queue_drained", out_q.size(), 0);
    chk("fault_queue_drained", fault_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
